// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EXE and WB.
// Drives the synchronous data RAM and formats load data for write-back.
module mem_stage #(
   parameter int LOAD_LATENCY = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         EXE_over,
   input  logic [105:0] EXE_MEM_bus,
   output logic         MEM_allow_in,
   input  logic         WB_allow_in,
   output logic [31:0]  dm_addr,
   output logic [3:0]   dm_wen,
   output logic [31:0]  dm_wdata,
   input  logic [31:0]  dm_rdata,
   output logic         MEM_over,
   output logic [69:0]  MEM_WB_bus,
   output logic [31:0]  MEM_pc
);

   typedef struct packed {
      logic        load;
      logic        store;
      logic        ls_word;
      logic        lb_sign;
      logic [31:0] store_data;
      logic [31:0] alu_result;
      logic        rf_wen;
      logic [4:0]  rf_wdest;
      logic [31:0] pc;
   } exe_mem_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      DONE
   } state_t;

   localparam logic [2:0] CNT_LAST = 3'(LOAD_LATENCY - 1);

   state_t      state;
   state_t      state_nx;
   exe_mem_t    bus_r;
   logic [31:0] mem_result;
   logic [31:0] mem_result_nx;
   logic [2:0]  cnt;
   logic [2:0]  cnt_nx;
   logic        accept;
   logic        is_store;
   logic        is_load;
   logic [31:0] word_addr;
   logic [7:0]  rbyte;
   logic [31:0] load_data;

   // A request with both load and store set behaves as a plain store.
   assign is_store  = bus_r.store;
   assign is_load   = bus_r.load & ~bus_r.store;
   assign word_addr = {bus_r.alu_result[31:2], 2'b00};

   assign MEM_allow_in = (state == IDLE)
                       | ((state == DONE) & WB_allow_in);
   assign accept       = EXE_over & MEM_allow_in;

   assign rbyte     = dm_rdata[{bus_r.alu_result[1:0], 3'b000} +: 8];
   assign load_data = bus_r.ls_word
                    ? dm_rdata
                    : {{24{bus_r.lb_sign & rbyte[7]}}, rbyte};

   always_comb begin
      state_nx      = state;
      cnt_nx        = cnt;
      mem_result_nx = mem_result;
      dm_addr       = '0;
      dm_wen        = '0;
      dm_wdata      = '0;
      MEM_over      = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) state_nx = ACCESS;
         end
         ACCESS: begin
            dm_addr = word_addr;
            if (is_store) begin
               if (bus_r.ls_word) begin
                  dm_wen   = 4'b1111;
                  dm_wdata = bus_r.store_data;
               end else begin
                  dm_wen   = 4'b0001 << bus_r.alu_result[1:0];
                  dm_wdata = {4{bus_r.store_data[7:0]}};
               end
               mem_result_nx = bus_r.alu_result;
               state_nx      = DONE;
            end else if (is_load) begin
               cnt_nx   = '0;
               state_nx = WAIT;
            end else begin
               mem_result_nx = bus_r.alu_result;
               state_nx      = DONE;
            end
         end
         WAIT: begin
            dm_addr = word_addr;
            cnt_nx  = cnt + 3'd1;
            // RAM data is valid in the last wait cycle only.
            if (cnt == CNT_LAST) begin
               mem_result_nx = load_data;
               state_nx      = DONE;
            end
         end
         DONE: begin
            MEM_over = 1'b1;
            if (WB_allow_in) state_nx = accept ? ACCESS : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bus_r      <= '0;
         mem_result <= '0;
         cnt        <= '0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         mem_result <= mem_result_nx;
         if (accept) bus_r <= EXE_MEM_bus;
      end
   end

   assign MEM_WB_bus = {bus_r.rf_wen, bus_r.rf_wdest,
                        mem_result, bus_r.pc};
   assign MEM_pc     = bus_r.pc;

endmodule
